// File: rtl/lsu_pkg.sv
// Shared encodings and helpers for the MEM-stage load/store controller.
// Size and state enums plus the alignment check live here.
package lsu_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_ACC0 = 2'b01,
    ST_ACC1 = 2'b10,
    ST_RESP = 2'b11
  } state_e;

  localparam int LANE_W = 8;

  // Reserved size is folded in so a single test decides the error path.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    logic bad;
    bad = 1'b0;
    case (size)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = addr_lo[0];
      SZ_WORD: bad = (addr_lo != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/lsu_mem_ctrl.sv
// MEM-stage load/store initiator for the dm_4k data memory.
// Halfwords are split into two byte accesses; every request gets one registered response.
module lsu_mem_ctrl
  import lsu_pkg::*;
#(
  parameter int AW = 12,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  input  logic          req_we,
  input  logic [1:0]    req_size,
  input  logic          req_signed,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  output logic          req_ready,
  output logic          stall,
  output logic          rsp_valid,
  output logic [DW-1:0] rsp_rdata,
  output logic          misalign_err,
  output logic          mRD,
  output logic          mWR,
  output logic          Byte,
  output logic          SigCtr,
  output logic [AW-1:0] DAddr,
  output logic [DW-1:0] DataIn,
  input  logic [DW-1:0] DataOut
);

  state_e              state;
  size_e               size_q;
  logic                we_q;
  logic                signed_q;
  logic [AW-1:0]       addr_q;
  logic [DW-1:0]       wdata_q;
  logic [LANE_W-1:0]   lo_q;

  assign req_ready = (state == ST_IDLE);
  assign stall     = req_valid & ~rsp_valid;

  // Memory-port signals are registered so they are glitch-free and an async reset
  // pulls mWR low at once, before the memory's negedge write can happen.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      size_q       <= SZ_BYTE;
      we_q         <= 1'b0;
      signed_q     <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      lo_q         <= '0;
      rsp_valid    <= 1'b0;
      rsp_rdata    <= '0;
      misalign_err <= 1'b0;
      mRD          <= 1'b0;
      mWR          <= 1'b0;
      Byte         <= 1'b0;
      SigCtr       <= 1'b0;
      DAddr        <= '0;
      DataIn       <= '0;
    end else begin
      rsp_valid <= 1'b0;
      mRD       <= 1'b0;
      mWR       <= 1'b0;
      Byte      <= 1'b0;
      SigCtr    <= 1'b0;
      DAddr     <= '0;
      DataIn    <= '0;

      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            size_q   <= size_e'(req_size);
            we_q     <= req_we;
            signed_q <= req_signed;
            addr_q   <= req_addr;
            wdata_q  <= req_wdata;
            if (is_misaligned(req_size, req_addr[1:0])) begin
              state        <= ST_RESP;
              rsp_valid    <= 1'b1;
              rsp_rdata    <= '0;
              misalign_err <= 1'b1;
            end else begin
              state  <= ST_ACC0;
              mRD    <= ~req_we;
              mWR    <= req_we;
              Byte   <= (size_e'(req_size) != SZ_WORD);
              SigCtr <= req_signed && (size_e'(req_size) == SZ_BYTE);
              DAddr  <= req_addr;
              DataIn <= (size_e'(req_size) == SZ_WORD) ? req_wdata
                                                       : {{(DW-LANE_W){1'b0}}, req_wdata[LANE_W-1:0]};
            end
          end
        end

        ST_ACC0: begin
          if (size_q == SZ_HALF) begin
            // Low byte is read unsigned; the high byte's sign extension covers the upper bits.
            state  <= ST_ACC1;
            lo_q   <= DataOut[LANE_W-1:0];
            mRD    <= ~we_q;
            mWR    <= we_q;
            Byte   <= 1'b1;
            SigCtr <= signed_q;
            DAddr  <= addr_q + {{(AW-1){1'b0}}, 1'b1};
            DataIn <= {{(DW-LANE_W){1'b0}}, wdata_q[2*LANE_W-1:LANE_W]};
          end else begin
            state        <= ST_RESP;
            rsp_valid    <= 1'b1;
            rsp_rdata    <= we_q ? '0 : DataOut;
            misalign_err <= 1'b0;
          end
        end

        ST_ACC1: begin
          state        <= ST_RESP;
          rsp_valid    <= 1'b1;
          rsp_rdata    <= we_q ? '0 : {DataOut[DW-LANE_W-1:0], lo_q};
          misalign_err <= 1'b0;
        end

        ST_RESP: begin
          state <= ST_IDLE;
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Self-checking bench for lsu_mem_ctrl with a behavioural dm_4k model.
// Expected responses are queued at drive time and popped when rsp_valid appears.
module tb_lsu_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [11:0] req_addr;
  logic [31:0] req_wdata;
  logic        req_ready;
  logic        stall;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        misalign_err;
  logic        mRD;
  logic        mWR;
  logic        Byte;
  logic        SigCtr;
  logic [11:0] DAddr;
  logic [31:0] DataIn;
  logic [31:0] DataOut;

  always #5 clk = ~clk;

  lsu_mem_ctrl #(.AW(12), .DW(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_we(req_we), .req_size(req_size),
    .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .stall(stall),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .misalign_err(misalign_err),
    .mRD(mRD), .mWR(mWR), .Byte(Byte), .SigCtr(SigCtr),
    .DAddr(DAddr), .DataIn(DataIn), .DataOut(DataOut)
  );

  // dm_4k model: combinational read, negedge write, little-endian lanes.
  logic [7:0] mem [0:4095];
  logic [7:0] rd_byte;

  always_comb begin
    rd_byte = mem[DAddr];
    if (Byte)
      DataOut = SigCtr ? {{24{rd_byte[7]}}, rd_byte} : {24'h0, rd_byte};
    else
      DataOut = {mem[{DAddr[11:2], 2'd3}], mem[{DAddr[11:2], 2'd2}],
                 mem[{DAddr[11:2], 2'd1}], mem[{DAddr[11:2], 2'd0}]};
  end

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } exp_t;

  typedef struct {
    logic [11:0] addr;
    logic [31:0] data;
    logic        is_byte;
    int          cyc;
  } wr_t;

  exp_t sb_queue[$];
  wr_t  wr_log[$];
  int   cycle_num = 0;
  int   rd_cycles = 0;
  int   wr_cycles = 0;
  int   both_cycles = 0;
  int   num_checks = 0;
  int   num_fails = 0;

  always @(posedge clk) cycle_num++;

  always @(negedge clk) begin
    if (mWR) begin
      wr_log.push_back('{DAddr, DataIn, Byte, cycle_num});
      wr_cycles++;
      if (Byte) begin
        mem[DAddr] = DataIn[7:0];
      end else begin
        mem[{DAddr[11:2], 2'd0}] = DataIn[7:0];
        mem[{DAddr[11:2], 2'd1}] = DataIn[15:8];
        mem[{DAddr[11:2], 2'd2}] = DataIn[23:16];
        mem[{DAddr[11:2], 2'd3}] = DataIn[31:24];
      end
    end
    if (mRD) rd_cycles++;
    if (mRD && mWR) both_cycles++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    num_checks++;
    if (actual !== expected) begin
      num_fails++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
    end
  endtask

  // Drives one request at the current negedge and waits for its response.
  task automatic applyStimulus(input logic we, input logic [1:0] size, input logic sgn,
                               input logic [11:0] addr, input logic [31:0] wdata,
                               input logic [31:0] exp_data, input logic exp_err, input int exp_lat);
    exp_t e;
    int   lat;
    int   guard;
    req_valid  = 1'b1;
    req_we     = we;
    req_size   = size;
    req_signed = sgn;
    req_addr   = addr;
    req_wdata  = wdata;
    sb_queue.push_back('{exp_data, exp_err, exp_lat});
    guard = 0;
    while (!req_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (!req_ready) checkOutput("accept_timeout", 32'(req_ready), 32'd1);
    wr_log.delete();
    rd_cycles = 0;
    wr_cycles = 0;
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    if (!rsp_valid) checkOutput("stall_busy", 32'(stall), 32'd1);
    while (!rsp_valid && lat < 20) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    e = sb_queue.pop_front();
    checkOutput("rsp_valid", 32'(rsp_valid), 32'd1);
    checkOutput("latency", 32'(lat), 32'(e.lat));
    checkOutput("rsp_rdata", rsp_rdata, e.rdata);
    checkOutput("misalign_err", 32'(misalign_err), 32'(e.err));
    checkOutput("stall_resp", 32'(stall), 32'd0);
    checkOutput("ready_resp", 32'(req_ready), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
    rst        = 1'b1;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_size   = 2'b00;
    req_signed = 1'b0;
    req_addr   = '0;
    req_wdata  = '0;
    repeat (3) @(negedge clk);

    checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("rst_rsp_rdata", rsp_rdata, 32'd0);
    checkOutput("rst_err", 32'(misalign_err), 32'd0);
    checkOutput("rst_mem_ctl", {28'd0, mRD, mWR, Byte, SigCtr}, 32'd0);
    checkOutput("rst_daddr", 32'(DAddr), 32'd0);
    checkOutput("rst_datain", DataIn, 32'd0);
    checkOutput("rst_ready", 32'(req_ready), 32'd1);
    checkOutput("rst_stall", 32'(stall), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Word store then word load.
    applyStimulus(1'b1, 2'b10, 1'b0, 12'h010, 32'hDEADBEEF, 32'h0, 1'b0, 2);
    checkOutput("wst_writes", 32'(wr_log.size()), 32'd1);
    if (wr_log.size() >= 1) begin
      checkOutput("wst_addr", 32'(wr_log[0].addr), 32'h010);
      checkOutput("wst_data", wr_log[0].data, 32'hDEADBEEF);
      checkOutput("wst_byte", 32'(wr_log[0].is_byte), 32'd0);
    end
    applyStimulus(1'b0, 2'b10, 1'b0, 12'h010, 32'h0, 32'hDEADBEEF, 1'b0, 2);
    checkOutput("wld_reads", 32'(rd_cycles), 32'd1);
    checkOutput("wld_writes", 32'(wr_cycles), 32'd0);

    // Byte store, then signed and unsigned byte loads.
    applyStimulus(1'b1, 2'b00, 1'b0, 12'h013, 32'hAAAAAA80, 32'h0, 1'b0, 2);
    checkOutput("bst_writes", 32'(wr_log.size()), 32'd1);
    if (wr_log.size() >= 1) begin
      checkOutput("bst_addr", 32'(wr_log[0].addr), 32'h013);
      checkOutput("bst_data", wr_log[0].data, 32'h00000080);
      checkOutput("bst_byte", 32'(wr_log[0].is_byte), 32'd1);
    end
    applyStimulus(1'b0, 2'b00, 1'b1, 12'h013, 32'h0, 32'hFFFFFF80, 1'b0, 2);
    applyStimulus(1'b0, 2'b00, 1'b0, 12'h013, 32'h0, 32'h00000080, 1'b0, 2);
    applyStimulus(1'b0, 2'b10, 1'b0, 12'h010, 32'h0, 32'h80ADBEEF, 1'b0, 2);

    // Half store split into two consecutive byte writes, then half loads.
    applyStimulus(1'b1, 2'b01, 1'b0, 12'h022, 32'h55558123, 32'h0, 1'b0, 3);
    checkOutput("hst_writes", 32'(wr_log.size()), 32'd2);
    if (wr_log.size() >= 2) begin
      checkOutput("hst_addr0", 32'(wr_log[0].addr), 32'h022);
      checkOutput("hst_data0", wr_log[0].data, 32'h00000023);
      checkOutput("hst_addr1", 32'(wr_log[1].addr), 32'h023);
      checkOutput("hst_data1", wr_log[1].data, 32'h00000081);
      checkOutput("hst_gap", 32'(wr_log[1].cyc - wr_log[0].cyc), 32'd1);
    end
    applyStimulus(1'b0, 2'b01, 1'b1, 12'h022, 32'h0, 32'hFFFF8123, 1'b0, 3);
    checkOutput("hld_reads", 32'(rd_cycles), 32'd2);
    applyStimulus(1'b0, 2'b01, 1'b0, 12'h022, 32'h0, 32'h00008123, 1'b0, 3);

    // Misaligned and reserved-size requests never touch memory.
    applyStimulus(1'b0, 2'b01, 1'b0, 12'h021, 32'h0, 32'h0, 1'b1, 1);
    checkOutput("mis_half_acc", 32'(rd_cycles + wr_cycles), 32'd0);
    applyStimulus(1'b0, 2'b10, 1'b0, 12'h012, 32'h0, 32'h0, 1'b1, 1);
    checkOutput("mis_word_acc", 32'(rd_cycles + wr_cycles), 32'd0);
    applyStimulus(1'b1, 2'b11, 1'b0, 12'h000, 32'hFFFFFFFF, 32'h0, 1'b1, 1);
    checkOutput("rsvd_acc", 32'(rd_cycles + wr_cycles), 32'd0);

    // Reset during ACC0 of a store must suppress the write.
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_size  = 2'b10;
    req_addr  = 12'h010;
    req_wdata = 32'h11223344;
    wr_cycles = 0;
    @(posedge clk);
    #1;
    checkOutput("abort_mwr_before", 32'(mWR), 32'd1);
    rst = 1'b1;
    #1;
    checkOutput("abort_mwr_after", 32'(mWR), 32'd0);
    checkOutput("abort_ctl", {28'd0, mRD, mWR, Byte, SigCtr}, 32'd0);
    checkOutput("abort_daddr", 32'(DAddr), 32'd0);
    checkOutput("abort_ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    checkOutput("abort_no_write", 32'(wr_cycles), 32'd0);
    req_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    applyStimulus(1'b0, 2'b10, 1'b0, 12'h010, 32'h0, 32'h80ADBEEF, 1'b0, 2);

    req_valid = 1'b0;
    @(negedge clk);
    checkOutput("rdata_hold", rsp_rdata, 32'h80ADBEEF);
    checkOutput("idle_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("rd_wr_overlap", 32'(both_cycles), 32'd0);
    checkOutput("sb_empty", 32'(sb_queue.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fails);
    $finish;
  end

  initial begin
    #50000;
    $display("[TB] FAIL global_timeout: got 0x00000001, expected 0x00000000");
    $fatal(1, "[TB] simulation time limit reached");
  end

endmodule

// File: doc/lsu_mem_ctrl.md
Name: lsu_mem_ctrl

Overview:
- MEM-stage load/store initiator for the pipelined CPU; drives the dm_4k data-memory port (mRD, mWR, Byte, SigCtr, DAddr, DataIn) and consumes DataOut.
- Adds halfword support on top of the byte/word memory by issuing two byte accesses.
- Checks alignment.
- Returns one registered response per request; holds the pipeline with a stall until that response.

Parameters:
- AW, 12, data-memory byte address width (DAddr width).
- DW, 32, data width.

Ports:
- clk  in  1  system clock, rising-edge state updates
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  MEM stage has a load/store; held stable until rsp_valid
- req_we  in  1  1=store, 0=load
- req_size  in  2  00=byte, 01=half, 10=word, 11=reserved
- req_signed  in  1  sign-extend sub-word load
- req_addr  in  AW  byte address
- req_wdata  in  DW  store data (low bits used for sub-word)
- req_ready  out  1  accepting a request (state IDLE)
- stall  out  1  pipeline hold
- rsp_valid  out  1  one-cycle response pulse
- rsp_rdata  out  DW  load result, 0 for stores/errors
- misalign_err  out  1  valid with rsp_valid; misaligned or reserved size
- mRD  out  1  memory read enable, active-high
- mWR  out  1  memory write enable, active-high (memory writes on negedge clk)
- Byte  out  1  byte-lane access
- SigCtr  out  1  memory sign-extends byte read
- DAddr  out  AW  memory byte address
- DataIn  out  DW  memory write data
- DataOut  in  DW  memory read data (combinational)

Behaviour:
- Reset: state IDLE; rsp_valid=0, rsp_rdata=0, misalign_err=0, mRD=mWR=Byte=SigCtr=0, DAddr=0, DataIn=0. Asserting rst mid-operation drops mWR immediately, so no partial write; an in-flight request is discarded.
- req_ready=(state==IDLE). stall=req_valid & ~rsp_valid (combinational).
- States:
  - IDLE: on req_valid, latch addr/size/we/signed/wdata.
    - Misaligned (half with addr[0]=1, word with addr[1:0]!=0) or size=11: go to RESP with err=1.
    - Otherwise go to ACC0.
  - ACC0: drive memory from latched regs.
    - DAddr=addr; Byte=(size!=word); mRD=~we; mWR=we.
    - SigCtr=signed for byte; SigCtr=0 for half low byte.
    - DataIn=wdata (word), or {24'b0,wdata[7:0]} (byte/half low).
    - At posedge: half goes to ACC1, capturing lo=DataOut[7:0]. Byte/word go to RESP, capturing DataOut (load) or 0 (store).
  - ACC1 (half only): DAddr=addr+1; Byte=1; SigCtr=signed; DataIn={24'b0,wdata[15:8]}; same mRD/mWR. At posedge capture rdata={DataOut[23:0],lo} (load) or 0, then go to RESP.
  - RESP: rsp_valid=1 for exactly one cycle; rsp_rdata and misalign_err valid. Go to IDLE.
- mRD/mWR are asserted only in ACC0/ACC1, never together. Outside access states all memory outputs are 0.
- Latency from the accept edge to rsp_valid high: byte/word 2 cycles, half 3, error 1.
- Addr+1 never wraps: an aligned half keeps addr+1 within the same word.
- Little-endian byte lanes: address[1:0]=00 maps to bits 7:0.
- rsp_rdata holds its value after RESP until the next capture.
- A request arriving during RESP is not accepted until IDLE; req_ready gates acceptance.

Decomposition:
- Shared package lsu_pkg holds:
  - size encodings SZ_BYTE/SZ_HALF/SZ_WORD/SZ_RSVD;
  - state encoding ST_IDLE/ST_ACC0/ST_ACC1/ST_RESP;
  - function is_misaligned(size, addr[1:0]).
- No sub-module needed; the memory-port output mux stays inline.

Test Plan:
- Word store 0xDEADBEEF @0x010, then word load @0x010 -> single mWR pulse in ACC0 with DAddr=0x010; load rsp_rdata=0xDEADBEEF, misalign_err=0, rsp 2 cycles after accept.
- Byte store 0x80 @0x013, then signed byte load and unsigned byte load @0x013 -> 0xFFFFFF80 and 0x00000080; Byte=1 in ACC0.
- Half store 0x8123 @0x022, then signed half load @0x022 -> byte writes 0x23@0x022 and 0x81@0x023 in consecutive cycles; rdata 0xFFFF8123; unsigned load gives 0x00008123; rsp 3 cycles after accept.
- Half load @0x021, word load @0x012, size=11 @0x000 -> each gives rsp_valid 1 cycle after accept with misalign_err=1, rdata=0, and mRD/mWR never asserted.
- Store issued and rst asserted during ACC0 before negedge -> mWR drops immediately, memory word unchanged, all outputs 0, state IDLE.
- stall high from req_valid until the rsp_valid cycle inclusive-low, i.e. stall=0 in the RESP cycle; back-to-back requests are accepted on the cycle after RESP.
